id_stage: RTL
=============

# id_stage

Parametrised, pipelined RV32I/RV64I instruction-decode stage with an integrated ID/EX register. It sits between fetch and execute. It decodes one instruction per cycle into operation fields and operands. Operands are resolved through a prioritised N-source forwarding network, load-use hazards are detected and stalled, and JAL redirects are raised one cycle after acceptance. Valid/ready handshakes on both sides and a synchronous flush support branch recovery.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64; immediates sign-extend to XLEN
- NFWD, 2: number of forwarding sources; index 0 is youngest (EX), highest priority

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  address of the instruction itself
- in_is  in  32  instruction word
- ra1, ra2  out  5  regfile read addresses (is[19:15], is[24:20]), combinational
- rn1, rn2  in  XLEN  regfile read data, same cycle
- fwd_wa  in  5*NFWD  forwarding destination addresses
- fwd_wn  in  XLEN*NFWD  forwarding data
- fwd_we  in  NFWD  forwarding write enables
- fwd_ld  in  NFWD  entry is a load whose data is not yet available
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute consumes
- t  out  7  opcode; st out 3 funct3; sst out 1 is[30]
- op1, op2  out  XLEN  operands
- outn  out  XLEN  offset/target/link (per opcode)
- out_pc  out  XLEN  instruction address
- wa  out  5  destination; we out 1 write enable
- illegal  out  1  unrecognised opcode
- jmp_valid  out  1  one-cycle JAL redirect pulse
- jmp_pc  out  XLEN  JAL target

## Operation
- Source read: src1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR. src2 is used by OP, STORE, BRANCH.
- Source resolution: reg 0 gives 0. Otherwise the lowest index i with fwd_we[i] and fwd_wa[i] equal to the register supplies fwd_wn[i]. If no entry matches, rn is used.
- Load-use hazard: a used source matches the winning entry i and fwd_ld[i] is set. Then in_ready is 0.
- in_ready = !hazard && (!out_valid || out_ready).
- Immediates: I {is[31:20]}, S {is[31:25],is[11:7]}, B {is[31],is[7],is[30:25],is[11:8],0}, U {is[31:12],12'h0}, J {is[31],is[19:12],is[20],is[30:21],0}. All immediates are sign-extended to XLEN.
- Shift immediates (funct3 001/101) use shamt is[24:20] when XLEN=32 and is[25:20] when XLEN=64. For shifts, op2 = zero-extended shamt.
- Per-opcode assignments:
  - LUI: op1=U, op2=0, we=1.
  - AUIPC: op1=U, op2=pc, we=1.
  - OP: op1=rs1, op2=rs2, we=1.
  - OP-IMM: op1=rs1, op2=I, we=1.
  - LOAD: op1=rs1, op2=I, we=1.
  - STORE: op1=rs1, op2=rs2, outn=S, we=0.
  - BRANCH: op1=rs1, op2=rs2, outn=pc+B, we=0.
  - JAL: op1=pc+4, op2=0, outn=pc+J, we=1, jmp_valid pulse with jmp_pc=pc+J.
  - JALR: op1=rs1, op2=I, outn=pc+4, we=1.
  - Any other opcode: illegal=1, we=0, op1=op2=outn=0. The instruction still occupies the stage.
- wa = is[11:7]. we is forced to 0 when wa = 0.
- in_is = 0 is treated as a bubble: accepted, but out_valid is not set.

## Timing
- Reset: all outputs register to 0 (out_valid, jmp_valid, illegal, we, op1, op2, outn, out_pc, t, st, sst, wa, jmp_pc).
- Latency: an accept in cycle N gives registered fields and out_valid=1 in cycle N+1.
- Consume without new accept: out_valid clears next cycle.
- Hazard stall: no accept. If the held instruction is consumed, a bubble follows (out_valid=0). Forwarding is re-evaluated every cycle, so the stall ends the cycle after fwd_ld drops.
- Back-pressure: while out_valid && !out_ready, all outputs hold stable.
- jmp_valid is high exactly the cycle after a JAL accept. It never repeats while that JAL is held.
- flush has priority over accept, consume and hazard:
  - next cycle out_valid=0 and jmp_valid=0;
  - the same-cycle in_valid is dropped;
  - in_ready may be 1 during a flush, but nothing is captured.
- rst mid-operation behaves as a flush plus clearing all fields to 0.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> all outputs 0, no accept. Then ADDI x1,x0,5 (0x00500093) at pc 0x100 -> next cycle out_valid=1, op1=0, op2=5, wa=1, we=1.
- Forward priority: ADD x3,x1,x2 with fwd0 (x1=0xAA), fwd1 (x1=0xBB), rn1=0xCC -> op1=0xAA. Drop fwd0 -> op1=0xBB. Set fwd_wa=0 with data 0x55 for a read of x0 -> op1=0.
- Load-use: fwd_ld[0]=1 on x1 for 2 cycles -> in_ready=0 for 2 cycles, one bubble. Instruction accepted in the 3rd cycle with forwarded data.
- JAL: 0x008000EF at pc 0x200 -> jmp_valid single pulse, jmp_pc=0x208, op1=0x204. Hold out_ready=0 for 3 cycles -> no repeat pulse.
- Flush: flush together with in_valid on a BRANCH -> out_valid=0 next cycle, no jmp_valid, the instruction is not held.
- XLEN=64: SRAI x5,x5,33 -> op2=33. LUI 0x80000 -> op1=0xFFFFFFFF80000000. Opcode 0x7F -> illegal=1, we=0.

Source files
------------

// File: rtl/id_stage_if.sv
// Fetch/regfile/forward/execute signal bundle for the decode stage.
// master is the stage itself, slave is the surrounding pipeline.
interface id_stage_if #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_is;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [XLEN-1:0]   rn1;
    logic [XLEN-1:0]   rn2;
    logic [5*NFWD-1:0] fwd_wa;
    logic [XLEN*NFWD-1:0] fwd_wn;
    logic [NFWD-1:0]   fwd_we;
    logic [NFWD-1:0]   fwd_ld;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        t;
    logic [2:0]        st;
    logic              sst;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   outn;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        wa;
    logic              we;
    logic              illegal;
    logic              jmp_valid;
    logic [XLEN-1:0]   jmp_pc;

    modport master (
        input  in_valid, in_pc, in_is, rn1, rn2,
        input  fwd_wa, fwd_wn, fwd_we, fwd_ld,
        input  flush, out_ready,
        output in_ready, ra1, ra2, out_valid,
        output t, st, sst, op1, op2, outn, out_pc,
        output wa, we, illegal, jmp_valid, jmp_pc
    );

    modport slave (
        output in_valid, in_pc, in_is, rn1, rn2,
        output fwd_wa, fwd_wn, fwd_we, fwd_ld,
        output flush, out_ready,
        input  in_ready, ra1, ra2, out_valid,
        input  t, st, sst, op1, op2, outn, out_pc,
        input  wa, we, illegal, jmp_valid, jmp_pc
    );
endinterface

// File: rtl/id_stage.sv
// RV32I/RV64I decode stage with forwarding, load-use stall,
// JAL redirect and an integrated ID/EX register.
module id_stage #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.master bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [6:0]      t;
        logic [2:0]      st;
        logic            sst;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] outn;
        logic [XLEN-1:0] pc;
        logic [4:0]      wa;
        logic            we;
        logic            ill;
    } id_ex_t;

    logic [31:0]     is;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;

    logic is_lui, is_auipc, is_op, is_opimm, is_load;
    logic is_store, is_branch, is_jal, is_jalr;
    logic use1, use2;

    logic [31:0]     i32, s32, b32, u32, j32;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [5:0]      shamt;
    logic            is_shift;
    logic [XLEN-1:0] pc4, pc_b, pc_j;

    logic [XLEN-1:0] v1, v2;
    logic            ld1, ld2;
    logic            hazard;
    logic            accept;
    logic            bubble;
    logic            load;

    id_ex_t          dec;
    id_ex_t          q;
    logic            out_valid_q;
    logic            jmp_valid_q;
    logic [XLEN-1:0] jmp_pc_q;

    assign is  = bus.in_is;
    assign opc = is[6:0];
    assign f3  = is[14:12];
    assign rd  = is[11:7];
    assign rs1 = is[19:15];
    assign rs2 = is[24:20];

    assign bus.ra1 = rs1;
    assign bus.ra2 = rs2;

    assign is_lui    = (opc == OPC_LUI);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_op     = (opc == OPC_OP);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);

    assign use1 = is_op | is_opimm | is_load |
                  is_store | is_branch | is_jalr;
    assign use2 = is_op | is_store | is_branch;

    assign i32 = {{20{is[31]}}, is[31:20]};
    assign s32 = {{20{is[31]}}, is[31:25], is[11:7]};
    assign b32 = {{19{is[31]}}, is[31], is[7],
                  is[30:25], is[11:8], 1'b0};
    assign u32 = {is[31:12], 12'h000};
    assign j32 = {{11{is[31]}}, is[31], is[19:12],
                  is[20], is[30:21], 1'b0};

    assign imm_i = XLEN'($signed(i32));
    assign imm_s = XLEN'($signed(s32));
    assign imm_b = XLEN'($signed(b32));
    assign imm_u = XLEN'($signed(u32));
    assign imm_j = XLEN'($signed(j32));

    // RV64 shifts take a 6-bit shamt; RV32 keeps is[25] out of it
    assign shamt = (XLEN == 64) ? is[25:20] : {1'b0, is[24:20]};
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign pc4  = bus.in_pc + XLEN'(4);
    assign pc_b = bus.in_pc + imm_b;
    assign pc_j = bus.in_pc + imm_j;

    // Walk oldest to youngest so the lowest matching index wins
    always_comb begin
        v1  = bus.rn1;
        ld1 = 1'b0;
        v2  = bus.rn2;
        ld2 = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (bus.fwd_we[i] && bus.fwd_wa[5*i +: 5] == rs1) begin
                v1  = bus.fwd_wn[XLEN*i +: XLEN];
                ld1 = bus.fwd_ld[i];
            end
            if (bus.fwd_we[i] && bus.fwd_wa[5*i +: 5] == rs2) begin
                v2  = bus.fwd_wn[XLEN*i +: XLEN];
                ld2 = bus.fwd_ld[i];
            end
        end
        if (rs1 == 5'd0) begin
            v1  = '0;
            ld1 = 1'b0;
        end
        if (rs2 == 5'd0) begin
            v2  = '0;
            ld2 = 1'b0;
        end
    end

    assign hazard = (use1 && ld1) || (use2 && ld2);
    assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign bubble = (is == 32'd0);
    assign load   = accept && !bubble;

    always_comb begin
        dec     = '0;
        dec.t   = opc;
        dec.st  = f3;
        dec.sst = is[30];
        dec.pc  = bus.in_pc;
        dec.wa  = rd;
        unique case (1'b1)
            is_lui: begin
                dec.op1 = imm_u;
                dec.we  = 1'b1;
            end
            is_auipc: begin
                dec.op1 = imm_u;
                dec.op2 = bus.in_pc;
                dec.we  = 1'b1;
            end
            is_op: begin
                dec.op1 = v1;
                dec.op2 = v2;
                dec.we  = 1'b1;
            end
            is_opimm: begin
                dec.op1 = v1;
                dec.op2 = is_shift ? XLEN'(shamt) : imm_i;
                dec.we  = 1'b1;
            end
            is_load: begin
                dec.op1 = v1;
                dec.op2 = imm_i;
                dec.we  = 1'b1;
            end
            is_store: begin
                dec.op1  = v1;
                dec.op2  = v2;
                dec.outn = imm_s;
            end
            is_branch: begin
                dec.op1  = v1;
                dec.op2  = v2;
                dec.outn = pc_b;
            end
            is_jal: begin
                dec.op1  = pc4;
                dec.outn = pc_j;
                dec.we   = 1'b1;
            end
            is_jalr: begin
                dec.op1  = v1;
                dec.op2  = imm_i;
                dec.outn = pc4;
                dec.we   = 1'b1;
            end
            default: begin
                dec.ill = 1'b1;
            end
        endcase
        if (rd == 5'd0) begin
            dec.we = 1'b0;
        end
    end

    // Fields only move on a real accept, so back-pressure holds them
    always_ff @(posedge clk) begin
        if (rst) begin
            q           <= '0;
            out_valid_q <= 1'b0;
            jmp_valid_q <= 1'b0;
            jmp_pc_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            jmp_valid_q <= 1'b0;
        end else begin
            jmp_valid_q <= load && is_jal;
            if (accept) begin
                out_valid_q <= !bubble;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (load) begin
                q <= dec;
                if (is_jal) begin
                    jmp_pc_q <= pc_j;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.t         = q.t;
    assign bus.st        = q.st;
    assign bus.sst       = q.sst;
    assign bus.op1       = q.op1;
    assign bus.op2       = q.op2;
    assign bus.outn      = q.outn;
    assign bus.out_pc    = q.pc;
    assign bus.wa        = q.wa;
    assign bus.we        = q.we;
    assign bus.illegal   = q.ill;
    assign bus.jmp_valid = jmp_valid_q;
    assign bus.jmp_pc    = jmp_pc_q;
endmodule
